// File: rtl/meas_filter.sv
// meas_filter: synchronises an asynchronous measurement-ready strobe,
// keeps the last four samples in a circular buffer and presents their
// truncated mean with a proximity flag under a valid/acknowledge handshake.
module meas_filter #(
  parameter logic [7:0] NEAR_TH = 8'd30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] meas,
  input  logic       measReady,
  input  logic       outAck,
  output logic [7:0] avg,
  output logic       outValid,
  output logic       warm,
  output logic       near,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, CAPTURE, SUM, PRESENT} state_t;

  state_t     state, state_nx;
  logic       s1, s2, s3;
  logic       sample_ev;
  logic [7:0] hold;
  logic [7:0] entries [4];
  logic [1:0] wr_ptr;
  logic [2:0] fill;
  logic [9:0] total;

  assign sample_ev = s2 & ~s3;
  assign warm      = (fill == 3'd4);

  // Two-flop synchroniser plus edge-detect delay flop for measReady
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= measReady;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: one pass through capture/sum, then wait for ack
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_ev) state_nx = CAPTURE;
      CAPTURE: state_nx = SUM;
      SUM:     state_nx = PRESENT;
      PRESENT: if (outAck) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Full-width sum of all four entries; 10 bits cannot overflow
  always_comb begin
    total = {2'b00, entries[0]} + {2'b00, entries[1]}
          + {2'b00, entries[2]} + {2'b00, entries[3]};
  end

  // Datapath: hold/buffer/pointer updates, registered result and flags.
  // The summing step registers the sum straight into its divided form (avg)
  // so outValid can rise on the same edge the sum is captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold     <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      avg      <= '0;
      near     <= 1'b0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) entries[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_ev) hold <= meas;
        end
        CAPTURE: begin
          entries[wr_ptr] <= hold;
          wr_ptr          <= wr_ptr + 2'd1;
          if (fill != 3'd4) fill <= fill + 3'd1;
        end
        SUM: begin
          avg      <= total[9:2];
          near     <= (total[9:2] < NEAR_TH);
          outValid <= 1'b1;
        end
        PRESENT: begin
          if (outAck) outValid <= 1'b0;
        end
        default: ;
      endcase
      if (sample_ev && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_meas_filter.sv
// tb_meas_filter: directed stimulus against a four-sample averaging model.
module tb_meas_filter;

  logic       clock;
  logic       reset;
  logic [7:0] meas;
  logic       measReady;
  logic       outAck;
  logic [7:0] avg;
  logic       outValid;
  logic       warm;
  logic       near;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  // reference model: last four accepted samples, zero until written
  int m_buf [4];
  int m_ptr;
  int m_cnt;
  int exp_avg;
  bit exp_near;
  bit exp_warm;
  bit chk_en;

  meas_filter #(.NEAR_TH(8'd30)) dut (
    .clock    (clock),
    .reset    (reset),
    .meas     (meas),
    .measReady(measReady),
    .outAck   (outAck),
    .avg      (avg),
    .outValid (outValid),
    .warm     (warm),
    .near     (near),
    .overrun  (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_buf[i] = 0;
    m_ptr = 0; m_cnt = 0; exp_avg = 0; exp_near = 0; exp_warm = 0;
  endtask

  task automatic model_push(input int v);
    int s;
    m_buf[m_ptr] = v;
    m_ptr = (m_ptr + 1) % 4;
    m_cnt++;
    s = m_buf[0] + m_buf[1] + m_buf[2] + m_buf[3];
    exp_avg  = s / 4;
    exp_near = (exp_avg < 30);
    exp_warm = (m_cnt >= 4);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_avg"}, avg, 0);
    chk({tag, "_valid"}, outValid, 0);
    chk({tag, "_warm"}, warm, 0);
    chk({tag, "_near"}, near, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic do_reset(input logic mr);
    chk_en    = 0;
    reset     = 1'b0;
    measReady = mr;
    outAck    = 1'b0;
    meas      = 8'd0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 chk_zero("rst");
    @(negedge clock);
    reset  = 1'b1;
    chk_en = 1;
  endtask

  // raise measReady ahead of edge 1; outValid must rise exactly at edge 5
  task automatic send(input int v);
    @(posedge clock);
    #1;
    meas      = v[7:0];
    measReady = 1'b1;
    model_push(v);
    repeat (4) @(posedge clock);
    #1 chk("lat_edge4", outValid, 0);
    @(posedge clock);
    #1 chk("lat_edge5", outValid, 1);
    measReady = 1'b0;
  endtask

  task automatic ack();
    outAck = 1'b1;
    @(posedge clock);
    #1;
    outAck = 1'b0;
    chk("ack_clears", outValid, 0);
    repeat (2) @(posedge clock);
  endtask

  // compare process: while a result is presented it must match the model
  always @(negedge clock) begin
    if (chk_en && reset && outValid) begin
      chk("cmp_avg", avg, exp_avg);
      chk("cmp_near", near, exp_near);
      chk("cmp_warm", warm, exp_warm);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit got;

    // first sample after reset: zeros dilute the mean
    do_reset(1'b0);
    send(40);
    chk("s40_avg", avg, 10);
    chk("s40_warm", warm, 0);
    chk("s40_near", near, 1);
    ack();

    // fill the buffer, then wrap the write pointer
    send(80);  ack();
    send(120); ack();
    send(160);
    chk("fill4_avg", avg, 100);
    chk("fill4_warm", warm, 1);
    chk("fill4_near", near, 0);
    ack();
    send(200);
    chk("wrap_avg", avg, 140);
    ack();

    // maximum values
    for (int i = 0; i < 4; i++) begin
      send(255);
      ack();
    end
    send(255);
    chk("max_avg", avg, 255);
    chk("max_overrun", overrun, 0);
    ack();

    // sample arriving during presentation is dropped and flagged
    do_reset(1'b0);
    send(100);
    chk("ovr_first_avg", avg, 25);
    repeat (6) @(posedge clock);
    #1 measReady = 1'b1;
    repeat (3) @(posedge clock);
    #1 measReady = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid_held", outValid, 1);
    chk("ovr_avg_held", avg, 25);
    ack();
    send(100);
    chk("ovr_next_avg", avg, 50);
    chk("ovr_sticky", overrun, 1);
    ack();

    // reset during SUM aborts cleanly, no partial buffer write survives
    do_reset(1'b0);
    @(posedge clock);
    #1;
    meas      = 8'd77;
    measReady = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk_en = 0;
    reset  = 1'b0;
    #1 chk_zero("midrst");
    measReady = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset  = 1'b1;
    chk_en = 1;
    send(60);
    chk("post_rst_avg", avg, 15);
    chk("post_rst_warm", warm, 0);
    ack();

    // measReady already high at reset release gives exactly one event
    do_reset(1'b1);
    meas = 8'd88;
    model_push(88);
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clock);
      #1 if (outValid) got = 1;
    end
    chk("held_ready_event", got, 1);
    chk("held_ready_avg", avg, 22);
    ack();
    repeat (10) @(posedge clock);
    #1 chk("held_ready_single", outValid, 0);
    chk("held_ready_no_ovr", overrun, 0);
    measReady = 1'b0;
    repeat (3) @(posedge clock);

    // near threshold and truncation
    do_reset(1'b0);
    send(119);
    chk("thr_avg29", avg, 29);
    chk("thr_near1", near, 1);
    ack();
    send(122);
    chk("trunc_avg60", avg, 60);
    chk("thr_near0", near, 0);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
